// File: rtl/wb_siggen_sequencer.sv
// Wishbone master that programs the signal generator, software-clocks it N times and samples its phases.
// Optional ack watchdog: define WB_SEQ_TIMEOUT_EN.
module wb_siggen_sequencer #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [3:0]  freq_i,
  input  logic [15:0] n_ticks_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [3:0]  phi_o,
  output logic        sample_valid_o,
  output logic [15:0] tick_count_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] W_EN0  = 4'd1;
  localparam logic [3:0] W_FREQ = 4'd2;
  localparam logic [3:0] W_EN1  = 4'd3;
  localparam logic [3:0] CHECK  = 4'd4;
  localparam logic [3:0] CLK_HI = 4'd5;
  localparam logic [3:0] CLK_LO = 4'd6;
  localparam logic [3:0] RD_P   = 4'd7;
  localparam logic [3:0] RD_L1  = 4'd8;
  localparam logic [3:0] RD_L2  = 4'd9;
  localparam logic [3:0] RD_R   = 4'd10;
  localparam logic [3:0] W_ENX  = 4'd11;
  localparam logic [3:0] FINISH = 4'd12;
  localparam logic [3:0] GAP    = 4'd13;

  logic [3:0]  state;
  logic [3:0]  ret;
  logic [3:0]  after_xfer;
  logic [3:0]  after_gap;
  logic [3:0]  launch_st;
  logic [3:0]  freq_q;
  logic [15:0] nticks_q;
  logic [2:0]  shadow;
  logic [7:0]  l_off;
  logic        l_we;
  logic [31:0] l_dat;
  logic        ack_seen;
  logic        abort;
  logic        launch;
  logic        unused_dat;

  assign ack_seen   = wbm_stb_o & wbm_ack_i;
  assign unused_dat = ^wbm_dat_i[31:1];

  // CHECK is resolved while in GAP so a tick costs exactly six bus slots
  always_comb begin
    after_xfer = IDLE;
    case (state)
      W_EN0:   after_xfer = W_FREQ;
      W_FREQ:  after_xfer = W_EN1;
      W_EN1:   after_xfer = CHECK;
      CLK_HI:  after_xfer = CLK_LO;
      CLK_LO:  after_xfer = RD_P;
      RD_P:    after_xfer = RD_L1;
      RD_L1:   after_xfer = RD_L2;
      RD_L2:   after_xfer = RD_R;
      RD_R:    after_xfer = CHECK;
      W_ENX:   after_xfer = FINISH;
      default: after_xfer = IDLE;
    endcase
    after_gap = ret;
    if (ret == CHECK) begin
      after_gap = (tick_count_o == nticks_q) ? W_ENX : CLK_HI;
    end
    launch_st = (state == IDLE) ? W_EN0 : after_gap;
    l_off = 8'h00;
    l_we  = 1'b1;
    l_dat = 32'd0;
    case (launch_st)
      W_FREQ: begin l_off = 8'h04; l_dat = {28'd0, freq_q}; end
      W_EN1:  l_dat = 32'd1;
      CLK_HI: begin l_off = 8'h18; l_dat = 32'd1; end
      CLK_LO: l_off = 8'h18;
      RD_P:   begin l_off = 8'h08; l_we = 1'b0; end
      RD_L1:  begin l_off = 8'h0C; l_we = 1'b0; end
      RD_L2:  begin l_off = 8'h10; l_we = 1'b0; end
      RD_R:   begin l_off = 8'h14; l_we = 1'b0; end
      default: ;
    endcase
    launch = (state == IDLE && start_i) || (state == GAP && after_gap != FINISH);
  end

`ifdef WB_SEQ_TIMEOUT_EN
  logic [7:0] wdog;
  logic       error_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !wbm_stb_o || wbm_ack_i) begin
      wdog <= 8'd0;
    end else begin
      wdog <= wdog + 8'd1;
    end
  end

  assign abort = wbm_stb_o & ~wbm_ack_i & (wdog == TIMEOUT_CYCLES - 8'd1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      error_q <= 1'b0;
    end else if (state == IDLE && start_i) begin
      error_q <= 1'b0;
    end else if (abort) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  logic unused_timeout;
  assign abort          = 1'b0;
  assign error_o        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
    end else if (launch) begin
      wbm_cyc_o <= 1'b1;
      wbm_stb_o <= 1'b1;
      wbm_we_o  <= l_we;
      wbm_sel_o <= 4'hF;
      wbm_adr_o <= BASE_ADDR + {24'd0, l_off};
      wbm_dat_o <= l_dat;
    end else if (ack_seen || abort) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= IDLE;
      ret            <= IDLE;
      freq_q         <= 4'd0;
      nticks_q       <= 16'd0;
      shadow         <= 3'd0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      phi_o          <= 4'd0;
      sample_valid_o <= 1'b0;
      tick_count_o   <= 16'd0;
    end else begin
      done_o         <= 1'b0;
      sample_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            freq_q       <= freq_i;
            nticks_q     <= n_ticks_i;
            tick_count_o <= 16'd0;
            busy_o       <= 1'b1;
            state        <= W_EN0;
          end
        end
        GAP: state <= after_gap;
        FINISH: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          if (ack_seen) begin
            ret   <= after_xfer;
            state <= GAP;
            case (state)
              RD_P:  shadow[0] <= wbm_dat_i[0];
              RD_L1: shadow[1] <= wbm_dat_i[0];
              RD_L2: shadow[2] <= wbm_dat_i[0];
              RD_R: begin
                phi_o          <= {wbm_dat_i[0], shadow};
                sample_valid_o <= 1'b1;
                tick_count_o   <= tick_count_o + 16'd1;
              end
              default: ;
            endcase
          end else if (abort) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_siggen_sequencer.sv
// Bench for wb_siggen_sequencer: Wishbone slave with registered ack, transaction log and phase model.
module tb_wb_siggen_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xact_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  freq = 4'd0;
  logic [15:0] nt = 16'd0;
  logic        busy, done, err, sv;
  logic [3:0]  phi;
  logic [15:0] tc;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dato, dati;
  logic        ack = 1'b0;

  always #5 clk = ~clk;

  wb_siggen_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .freq_i(freq), .n_ticks_i(nt),
    .busy_o(busy), .done_o(done), .error_o(err), .phi_o(phi), .sample_valid_o(sv),
    .tick_count_o(tc), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dato), .wbm_dat_i(dati), .wbm_ack_i(ack)
  );

  int          lat = 0;
  bit          never_ack = 1'b0;
  bit          rand_phase = 1'b1;
  logic [3:0]  phase = 4'd0;   // {r, l2, l1, p} held by the generator model
  logic [30:0] junk = 31'h5A5A_1234;
  int          wait_cnt = 0;
  int          cyc_n = 0;
  int          passes = 0;
  int          total = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          stb_cycles = 0;
  xact_t       got_q[$];
  xact_t       exp_q[$];
  logic [3:0]  got_phi[$];
  logic [3:0]  exp_phi[$];
  int          sv_cyc[$];

  // Slave acks a configurable number of cycles after stb; the registered ack leaves one trailing ack
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (!(cyc && stb)) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    ack <= cyc && stb && !never_ack && (wait_cnt >= lat);
  end

  always_comb begin
    logic b;
    b = 1'b0;
    if (adr == BASE + 32'h08) b = phase[0];
    else if (adr == BASE + 32'h0C) b = phase[1];
    else if (adr == BASE + 32'h10) b = phase[2];
    else if (adr == BASE + 32'h14) b = phase[3];
    dati = {junk, b};
  end

  always @(negedge clk) begin
    xact_t t;
    if (cyc && stb && ack) begin
      t.we  = we;
      t.adr = adr;
      t.dat = we ? dato : 32'h0;
      got_q.push_back(t);
      if (we && adr == BASE + 32'h18 && dato == 32'd1) begin
        if (rand_phase) phase = 4'($urandom);
        exp_phi.push_back(phase);
        junk = 31'($urandom);
      end
    end
    if (sv) begin
      got_phi.push_back(phi);
      sv_cyc.push_back(cyc_n);
    end
    if (done) done_cnt++;
    if (stb) stb_cycles++;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    total++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic xact_t mk(input logic w, input logic [7:0] off, input logic [31:0] d);
    xact_t t;
    t.we  = w;
    t.adr = BASE + {24'd0, off};
    t.dat = d;
    return t;
  endfunction

  // Expected bus traffic written from the register-level description of a sequence
  task automatic build_exp(input logic [3:0] f, input int n);
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 8'h00, 32'd0));
    exp_q.push_back(mk(1'b1, 8'h04, {28'd0, f}));
    exp_q.push_back(mk(1'b1, 8'h00, 32'd1));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk(1'b1, 8'h18, 32'd1));
      exp_q.push_back(mk(1'b1, 8'h18, 32'd0));
      exp_q.push_back(mk(1'b0, 8'h08, 32'd0));
      exp_q.push_back(mk(1'b0, 8'h0C, 32'd0));
      exp_q.push_back(mk(1'b0, 8'h10, 32'd0));
      exp_q.push_back(mk(1'b0, 8'h14, 32'd0));
    end
    exp_q.push_back(mk(1'b1, 8'h00, 32'd0));
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_phi.delete();
    exp_phi.delete();
    sv_cyc.delete();
    done_cnt   = 0;
    stb_cycles = 0;
  endtask

  task automatic start_seq(input logic [3:0] f, input logic [15:0] n);
    @(negedge clk);
    freq  = f;
    nt    = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_done_seen"}, 96'(done_cnt != 0), 96'd1);
  endtask

  task automatic check_seq(input string tag, input logic [3:0] f, input int n);
    int m;
    build_exp(f, n);
    chk({tag, "_xact_count"}, 96'(got_q.size()), 96'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, "_xact"}, 96'(got_q[i]), 96'(exp_q[i]));
    chk({tag, "_samples"}, 96'(got_phi.size()), 96'(n));
    m = (got_phi.size() < exp_phi.size()) ? got_phi.size() : exp_phi.size();
    for (int i = 0; i < m; i++) chk({tag, "_phi"}, 96'(got_phi[i]), 96'(exp_phi[i]));
    if (lat == 0) begin
      for (int i = 1; i < sv_cyc.size(); i++)
        chk({tag, "_tick_spacing"}, 96'(sv_cyc[i] - sv_cyc[i-1]), 96'd18);
    end
    chk({tag, "_tick_count"}, 96'(tc), 96'(n));
    chk({tag, "_done_pulses"}, 96'(done_cnt), 96'd1);
    chk({tag, "_busy_after"}, 96'(busy), 96'd0);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_adr"}, 96'(adr), 96'd0);
    chk({tag, "_dat"}, 96'(dato), 96'd0);
    chk({tag, "_ctl"}, 96'({cyc, stb, we, sel, busy, done, sv, phi, tc, err}), 96'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] f;
    int         n;

    // Power-on reset
    repeat (3) @(negedge clk);
    chk("reset_adr", 96'(adr), 96'd0);
    chk("reset_dat", 96'(dato), 96'd0);
    chk("reset_ctl", 96'({cyc, stb, we, sel, busy, done, sv, phi, tc, err}), 96'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero ticks: only the enable/frequency/enable/disable writes
    clear_obs();
    start_seq(4'h3, 16'd0);
    chk("zero_busy", 96'(busy), 96'd1);
    wait_done("zero", 500);
    check_seq("zero", 4'h3, 0);

    // Three ticks with randomly evolving generator phases
    clear_obs();
    f = 4'($urandom);
    start_seq(f, 16'd3);
    wait_done("three", 1000);
    check_seq("three", f, 3);

    // Fixed phase pattern p=1, l1=0, l2=1, r=1
    clear_obs();
    rand_phase = 1'b0;
    phase = 4'b1101;
    start_seq(4'h9, 16'd2);
    wait_done("fixed", 1000);
    check_seq("fixed", 4'h9, 2);
    chk("fixed_phi_value", 96'(phi), 96'(4'b1101));
    rand_phase = 1'b1;

    // Second start while busy must be ignored
    clear_obs();
    start_seq(4'hA, 16'd5);
    repeat (4) @(negedge clk);
    chk("busy_restart_busy", 96'(busy), 96'd1);
    start_seq(4'h5, 16'd1);
    wait_done("busy_restart", 2000);
    check_seq("busy_restart", 4'hA, 5);

    // Randomised slave latency, frequency and tick count
    for (int r = 0; r < 3; r++) begin
      clear_obs();
      lat = $urandom_range(1, 3);
      f = 4'($urandom);
      n = $urandom_range(1, 4);
      start_seq(f, 16'(n));
      wait_done("rand", 3000);
      check_seq("rand", f, n);
    end
    lat = 0;

    // Slave that never acknowledges
    clear_obs();
    never_ack = 1'b1;
    start_seq(4'h7, 16'd2);
`ifdef WB_SEQ_TIMEOUT_EN
    n = 0;
    while (cyc && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cyc", 96'({cyc, stb}), 96'd0);
    chk("timeout_stb_cycles", 96'(stb_cycles), 96'd255);
    chk("timeout_error", 96'(err), 96'd1);
    chk("timeout_busy", 96'(busy), 96'd0);
    chk("timeout_no_done", 96'(done_cnt), 96'd0);
    never_ack = 1'b0;
    clear_obs();
    start_seq(4'h2, 16'd0);
    chk("timeout_error_cleared", 96'(err), 96'd0);
    wait_done("after_timeout", 500);
    check_seq("after_timeout", 4'h2, 0);
`else
    repeat (300) @(negedge clk);
    chk("hang_cyc_stb", 96'({cyc, stb}), 96'd3);
    chk("hang_error", 96'(err), 96'd0);
    chk("hang_busy", 96'(busy), 96'd1);
    chk("hang_no_done", 96'(done_cnt), 96'd0);
    never_ack = 1'b0;
    reset_check("hang_reset");
`endif

    // Reset in the middle of a running sequence
    clear_obs();
    start_seq(4'hC, 16'd2);
    repeat (10) @(negedge clk);
    reset_check("mid_reset");
    clear_obs();
    repeat (30) @(negedge clk);
    chk("mid_reset_quiet", 96'(stb_cycles), 96'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
